// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and width constants for the FIFO pointer counters.
package gray_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH = 32;
  typedef logic [MAX_WIDTH-1:0] word_t;
  function automatic word_t width_mask(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction
  function automatic word_t bin2gray(input word_t value, input int width);
    word_t v;
    v = value & width_mask(width);
    return v ^ (v >> 1);
  endfunction
  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic word_t gray2bin(input word_t value, input int width);
    word_t g;
    word_t b;
    logic acc;
    g = value & width_mask(width);
    b = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      acc = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and count bundle between a FIFO pointer user and its Gray counter.
interface gray_counter_if import gray_pkg::*; #(parameter int COUNTER_WIDTH = DEFAULT_WIDTH);
  logic Clear_in;
  logic Enable_in;
  logic [COUNTER_WIDTH-1:0] GrayCount_out;
  modport master (output Clear_in, output Enable_in, input GrayCount_out);
  modport slave (input Clear_in, input Enable_in, output GrayCount_out);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: registered Gray-code counter; the binary register runs one count ahead of the output.
module gray_counter import gray_pkg::*; #(
  parameter int COUNTER_WIDTH = DEFAULT_WIDTH
) (
  input logic Clk,
  input logic Rst_n,
  gray_counter_if.slave bus
);
  logic [COUNTER_WIDTH-1:0] bin_q;
  logic [COUNTER_WIDTH-1:0] gray_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bin_q <= COUNTER_WIDTH'(1);
      gray_q <= '0;
    end else if (bus.Clear_in) begin
      bin_q <= COUNTER_WIDTH'(1);
      gray_q <= '0;
    end else if (bus.Enable_in) begin
      gray_q <= COUNTER_WIDTH'(bin2gray(word_t'(bin_q), COUNTER_WIDTH));
      bin_q <= bin_q + COUNTER_WIDTH'(1);
    end
  end
  assign bus.GrayCount_out = gray_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: scoreboard bench for a width-4 and a width-3 Gray counter sharing one clock.
module tb_gray_counter;
  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  always #5 Clk = ~Clk;

  gray_counter_if #(.COUNTER_WIDTH(4)) if4 ();
  gray_counter_if #(.COUNTER_WIDTH(3)) if3 ();

  gray_counter #(.COUNTER_WIDTH(4)) dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(if4));
  gray_counter #(.COUNTER_WIDTH(3)) dut3 (.Clk(Clk), .Rst_n(Rst_n), .bus(if3));

  typedef struct {
    logic [3:0] exp;
    bit hop;
    bit w3;
    string name;
  } entry_t;

  entry_t sb[$];
  int total = 0;
  int bad = 0;
  logic [3:0] prev [2];

  logic [3:0] seq4 [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] seq3 [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'h0};

  initial begin
    prev[0] = '0;
    prev[1] = '0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      #1;
      while (sb.size() != 0) begin
        entry_t e;
        logic [3:0] act;
        int sel;
        e = sb.pop_front();
        sel = e.w3 ? 1 : 0;
        act = e.w3 ? {1'b0, if3.GrayCount_out} : if4.GrayCount_out;
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
        if (e.hop) begin
          total++;
          if ($countones(act ^ prev[sel]) != 1) begin
            bad++;
            $display("FAIL %s hamming: got %h after %h, bits changed %0d expected 1", e.name, act, prev[sel], $countones(act ^ prev[sel]));
          end
        end
        prev[sel] = act;
      end
    end
  end

  task automatic step(input logic clr, input logic en, input logic [3:0] e, input bit hop, input bit w3, input string name);
    @(negedge Clk);
    if4.Clear_in = w3 ? 1'b0 : clr;
    if4.Enable_in = w3 ? 1'b0 : en;
    if3.Clear_in = w3 ? clr : 1'b0;
    if3.Enable_in = w3 ? en : 1'b0;
    sb.push_back('{exp: e, hop: hop, w3: w3, name: name});
    @(posedge Clk);
  endtask

  task automatic expect_reset(input string name);
    sb.push_back('{exp: 4'h0, hop: 1'b0, w3: 1'b0, name: {name, "_w4"}});
    sb.push_back('{exp: 4'h0, hop: 1'b0, w3: 1'b1, name: {name, "_w3"}});
  endtask

  initial begin
    if4.Clear_in = 1'b0;
    if4.Enable_in = 1'b0;
    if3.Clear_in = 1'b0;
    if3.Enable_in = 1'b0;
    #2;
    expect_reset("reset");
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "idle");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, seq4[i], 1'b1, 1'b0, "period");
    step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "gap_en");
    step(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, "gap_hold1");
    step(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, "gap_hold2");
    step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, "gap_resume");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "to6_a");
    step(1'b0, 1'b1, 4'h6, 1'b1, 1'b0, "to6_b");
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "clear_prio");
    step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "after_clr1");
    step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, "after_clr3");
    for (int i = 2; i < 9; i++) step(1'b0, 1'b1, seq4[i], 1'b1, 1'b0, "toD");
    #3;
    expect_reset("async_rst");
    Rst_n = 1'b0;
    @(negedge Clk);
    if4.Enable_in = 1'b0;
    Rst_n = 1'b1;
    step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "post_rst1");
    step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, "post_rst3");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, seq3[i], 1'b1, 1'b1, "w3_period");
    @(negedge Clk);
    if3.Enable_in = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
